// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the load/store operation codes, the FSM state encoding, the bus timeout
// limit and the reset/zero constants. It also provides small decode helpers that
// both the top level and the lane formatter use.
package mem_access_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [7:0]  TimeoutLimit = 8'd255;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic size_t access_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SZ_WORD;
            default:                          return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lane_fmt.sv
// mem_lane_fmt: combinational big-endian lane handling for the memory stage.
// It generates byte enables from the access width and the low address bits.
// Store data is replicated across all lanes. Load data is extracted from the
// addressed lane and then sign- or zero-extended. Only addr[1:0] are looked at,
// so a misaligned halfword or word simply ignores the bits below its width.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    size_t       size;

    assign size = access_size(aluop);

    // Select the addressed byte / halfword; address 0 is the most significant lane
    always_comb begin
        byte_lane = rdata[31:24];
        case (addr_lo)
            2'b00:   byte_lane = rdata[31:24];
            2'b01:   byte_lane = rdata[23:16];
            2'b10:   byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Byte enables for the access width and position
    always_comb begin
        sel = 4'b0000;
        case (size)
            SZ_BYTE: sel = 4'b1000 >> addr_lo;
            SZ_HALF: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
    end

    // Store data replicated so that every enabled lane sees the right bits
    always_comb begin
        wdata = ZeroWord;
        if (is_store_op(aluop)) begin
            case (size)
                SZ_BYTE: wdata = {4{reg2[7:0]}};
                SZ_HALF: wdata = {2{reg2[15:0]}};
                SZ_WORD: wdata = reg2;
                default: wdata = ZeroWord;
            endcase
        end
    end

    // Load result with sign or zero extension
    always_comb begin
        load_data = ZeroWord;
        case (aluop)
            EXE_LB_OP:  load_data = {{24{byte_lane[7]}}, byte_lane};
            EXE_LBU_OP: load_data = {24'h00_0000, byte_lane};
            EXE_LH_OP:  load_data = {{16{half_lane[15]}}, half_lane};
            EXE_LHU_OP: load_data = {16'h0000, half_lane};
            EXE_LW_OP:  load_data = rdata;
            default:    load_data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with a simple request/ack data bus.
// Non-memory ops pass through combinationally. A load or store raises dbus_req
// and stallreq in IDLE, then waits in BUSY for dbus_ack. The result appears for
// one cycle in DONE.
// Bus handshake: dbus_req, dbus_we, dbus_sel, dbus_addr and dbus_wdata stay
// stable while dbus_req=1. The transfer completes on the first rising edge
// where dbus_ack=1. An ack seen in IDLE with a request up completes at once
// ("zero-wait"). An ack with no request outstanding is ignored.
// If no ack arrives by wait count 255, the access aborts, bus_err pulses and
// nothing is written back.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses
// skip the bus entirely and pulse align_err.
// fsm_state exposes the controller state for observation.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stallreq,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output state_t      fsm_state
);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [7:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] reg2_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] rdata_q;
    logic        bus_err_q;
    logic        align_q;

    logic [7:0]  cur_op;
    logic [31:0] cur_addr;
    logic [31:0] cur_reg2;
    logic        cur_is_mem;
    logic        align_fault;
    logic        issue;
    logic        req, stall;
    logic        rst_off;
    logic [3:0]  fmt_sel;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;

    // In IDLE the live EX/MEM inputs drive the access. Afterwards the copy
    // latched on leaving IDLE keeps the bus stable regardless of the inputs.
    assign cur_op     = (state_q == IDLE) ? ex_aluop    : op_q;
    assign cur_addr   = (state_q == IDLE) ? ex_mem_addr : addr_q;
    assign cur_reg2   = (state_q == IDLE) ? ex_reg2     : reg2_q;
    assign cur_is_mem = is_load_op(cur_op) || is_store_op(cur_op);
    assign rst_off    = (rst != RstEnable);

`ifdef MEM_ALIGN_CHECK_EN
    size_t cur_size;
    assign cur_size    = access_size(cur_op);
    assign align_fault = (state_q == IDLE) &&
                         (((cur_size == SZ_HALF) && cur_addr[0]) ||
                          ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)));
`else
    assign align_fault = 1'b0;
`endif

    assign issue = (state_q == IDLE) && cur_is_mem && !align_fault;

    mem_lane_fmt u_lane_fmt (
        .aluop     (cur_op),
        .addr_lo   (cur_addr[1:0]),
        .reg2      (cur_reg2),
        .rdata     (dbus_rdata),
        .sel       (fmt_sel),
        .wdata     (fmt_wdata),
        .load_data (fmt_load)
    );

    // Next-state decode plus the write-back result for each state
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        stall     = 1'b0;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        mem_wdata = ZeroWord;
        case (state_q)
            IDLE: begin
                if (cur_is_mem) begin
                    stall = 1'b1;
                    if (align_fault) begin
                        state_d = DONE;
                    end else begin
                        req     = 1'b1;
                        state_d = dbus_ack ? DONE : BUSY;
                    end
                end else begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg;
                    mem_wdata = ex_wdata;
                end
            end
            BUSY: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dbus_ack || (wait_cnt == TimeoutLimit)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                mem_wd    = wd_q;
                mem_wreg  = wreg_q && is_load_op(op_q) && !bus_err_q && !align_q;
                mem_wdata = rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and stall outputs; reset removes the request immediately
    assign dbus_req   = req && rst_off;
    assign stallreq   = stall && rst_off;
    assign dbus_we    = dbus_req && is_store_op(cur_op);
    assign dbus_sel   = dbus_req ? fmt_sel : 4'b0000;
    assign dbus_addr  = dbus_req ? {cur_addr[31:2], 2'b00} : ZeroWord;
    assign dbus_wdata = dbus_req ? fmt_wdata : ZeroWord;
    assign bus_err    = bus_err_q;
    assign fsm_state  = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the access description while idle so BUSY/DONE see a frozen copy
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            op_q   <= 8'd0;
            addr_q <= ZeroWord;
            reg2_q <= ZeroWord;
            wd_q   <= 5'd0;
            wreg_q <= 1'b0;
        end else if (state_q == IDLE) begin
            op_q   <= ex_aluop;
            addr_q <= ex_mem_addr;
            reg2_q <= ex_reg2;
            wd_q   <= ex_wd;
            wreg_q <= ex_wreg;
        end
    end

    // Wait counter: zero while idle, counts BUSY cycles without ack, saturates at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            wait_cnt <= 8'd0;
        end else if (state_q == IDLE) begin
            wait_cnt <= 8'd0;
        end else if ((state_q == BUSY) && !dbus_ack && (wait_cnt != TimeoutLimit)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Capture load data on the ack edge. A timeout captures zero and raises bus_err.
    // An ack on the timeout edge takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rdata_q   <= ZeroWord;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state_q == IDLE) begin
                rdata_q <= (issue && dbus_ack) ? fmt_load : ZeroWord;
            end else if (state_q == BUSY) begin
                if (dbus_ack) begin
                    rdata_q <= fmt_load;
                end else if (wait_cnt == TimeoutLimit) begin
                    rdata_q   <= ZeroWord;
                    bus_err_q <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle alignment fault flag, visible during the DONE that follows
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            align_q <= 1'b0;
        end else begin
            align_q <= align_fault;
        end
    end
    assign align_err = align_q;
`else
    assign align_q = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: passthrough, load/store lane formatting,
// wait states, zero-wait ack, bus timeout, ack-at-limit and reset mid-access.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif
    state_t      fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_aluop    (ex_aluop),
        .ex_mem_addr (ex_mem_addr),
        .ex_reg2     (ex_reg2),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .stallreq    (stallreq),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_sel    (dbus_sel),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_ack    (dbus_ack),
        .dbus_rdata  (dbus_rdata),
        .bus_err     (bus_err),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err   (align_err),
`endif
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_aluop    = op;
        ex_mem_addr = addr;
        ex_reg2     = reg2;
        ex_wd       = wd;
        ex_wreg     = wreg;
        ex_wdata    = wdata;
    endtask

    task automatic drive_nop();
        drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    // Runs one access whose inputs are already driven (called just after a rising edge).
    // ack_cycle: cycle index (0 = IDLE cycle) on which dbus_ack is raised; -1 = never.
    task automatic access(input string tag, input int ack_cycle, input logic [31:0] rdata,
                          input int exp_stalls, input logic [3:0] exp_sel, input logic exp_we,
                          input logic [31:0] exp_addr, input logic [31:0] exp_bwdata,
                          input logic [4:0] exp_wd, input logic exp_wreg,
                          input logic [31:0] exp_wdata, input logic exp_err);
        int          stalls;
        logic        stable;
        logic        done_seen;
        logic [3:0]  sel0;
        logic        we0;
        logic        req0;
        logic [31:0] addr0, wdata0;
        stalls    = 0;
        stable    = 1'b1;
        done_seen = 1'b0;
        sel0 = '0; we0 = 1'b0; req0 = 1'b0; addr0 = '0; wdata0 = '0;
        dbus_rdata = rdata;
        for (int k = 0; k < 400; k++) begin
            dbus_ack = (k == ack_cycle);
            @(negedge clk);
            if (!stallreq) begin
                done_seen = 1'b1;
                check({tag, "_state_done"}, 32'(fsm_state), 32'(DONE));
                check({tag, "_mem_wd"}, 32'(mem_wd), 32'(exp_wd));
                check({tag, "_mem_wreg"}, 32'(mem_wreg), 32'(exp_wreg));
                check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
                check({tag, "_bus_err"}, 32'(bus_err), 32'(exp_err));
                check({tag, "_done_req"}, 32'(dbus_req), 32'd0);
                break;
            end
            stalls++;
            if (k == 0) begin
                req0 = dbus_req; sel0 = dbus_sel; we0 = dbus_we;
                addr0 = dbus_addr; wdata0 = dbus_wdata;
            end else if (dbus_req !== req0 || dbus_sel !== sel0 || dbus_we !== we0 ||
                         dbus_addr !== addr0 || dbus_wdata !== wdata0) begin
                stable = 1'b0;
            end
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
        check({tag, "_completed"}, 32'(done_seen), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_req"}, 32'(req0), 32'd1);
        check({tag, "_sel"}, 32'(sel0), 32'(exp_sel));
        check({tag, "_we"}, 32'(we0), 32'(exp_we));
        check({tag, "_addr"}, addr0, exp_addr);
        check({tag, "_bwdata"}, wdata0, exp_bwdata);
        check({tag, "_stable"}, 32'(stable), 32'd1);
        // Back to IDLE with a NOP: error flag gone, nothing requested
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        check({tag, "_idle"}, 32'(fsm_state), 32'(IDLE));
        check({tag, "_err_cleared"}, 32'(bus_err), 32'd0);
        @(posedge clk); #1;
    endtask

    // Stimulus
    initial begin
        rst = 1'b0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;
        drive(EXE_LW_OP, 32'h0000_0100, 32'h0, 5'd1, 1'b1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_stall", 32'(stallreq), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        drive(ADD_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_0005);
        rst = 1'b1;
        @(negedge clk);
        check("add_wdata", mem_wdata, 32'h0000_0005);
        check("add_wreg", 32'(mem_wreg), 32'd1);
        check("add_wd", 32'(mem_wd), 32'd3);
        check("add_stall", 32'(stallreq), 32'd0);
        check("add_req", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;

        drive(EXE_LB_OP, 32'h0000_1001, 32'h0, 5'd7, 1'b1, 32'h0);
        access("lb", 3, 32'h1280_FF00, 4, 4'b0100, 1'b0, 32'h0000_1000, 32'h0,
               5'd7, 1'b1, 32'hFFFF_FF80, 1'b0);
        drive(EXE_SH_OP, 32'h0000_2002, 32'h0000_ABCD, 5'd4, 1'b1, 32'h0);
        access("sh", 0, 32'h0, 1, 4'b0011, 1'b1, 32'h0000_2000, 32'hABCD_ABCD,
               5'd4, 1'b0, 32'h0, 1'b0);
        drive(EXE_LHU_OP, 32'h0000_0042, 32'h0, 5'd5, 1'b1, 32'h0);
        access("lhu", 1, 32'h1234_8765, 2, 4'b0011, 1'b0, 32'h0000_0040, 32'h0,
               5'd5, 1'b1, 32'h0000_8765, 1'b0);
        drive(EXE_LH_OP, 32'h0000_0040, 32'h0, 5'd6, 1'b1, 32'h0);
        access("lh", 0, 32'h8765_1234, 1, 4'b1100, 1'b0, 32'h0000_0040, 32'h0,
               5'd6, 1'b1, 32'hFFFF_8765, 1'b0);
        drive(EXE_LBU_OP, 32'h0000_0003, 32'h0, 5'd8, 1'b1, 32'h0);
        access("lbu", 2, 32'h0000_00F0, 3, 4'b0001, 1'b0, 32'h0000_0000, 32'h0,
               5'd8, 1'b1, 32'h0000_00F0, 1'b0);
        drive(EXE_SB_OP, 32'h0000_0010, 32'h1234_5678, 5'd9, 1'b1, 32'h0);
        access("sb", 1, 32'h0, 2, 4'b1000, 1'b1, 32'h0000_0010, 32'h7878_7878,
               5'd9, 1'b0, 32'h0, 1'b0);
        drive(EXE_LW_OP, 32'h0000_0104, 32'h0, 5'd10, 1'b1, 32'h0);
        access("lw", 5, 32'hDEAD_BEEF, 6, 4'b1111, 1'b0, 32'h0000_0104, 32'h0,
               5'd10, 1'b1, 32'hDEAD_BEEF, 1'b0);
`ifndef MEM_ALIGN_CHECK_EN
        // Low address bits below the access width are ignored
        drive(EXE_SW_OP, 32'h2000_0007, 32'hCAFE_F00D, 5'd11, 1'b1, 32'h0);
        access("sw_mis", 0, 32'h0, 1, 4'b1111, 1'b1, 32'h2000_0004, 32'hCAFE_F00D,
               5'd11, 1'b0, 32'h0, 1'b0);
`else
        drive(EXE_LW_OP, 32'h0000_0202, 32'h0, 5'd11, 1'b1, 32'h0);
        @(negedge clk);
        check("al_req", 32'(dbus_req), 32'd0);
        check("al_stall", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("al_state", 32'(fsm_state), 32'(DONE));
        check("al_err", 32'(align_err), 32'd1);
        check("al_wreg", 32'(mem_wreg), 32'd0);
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        check("al_err_clr", 32'(align_err), 32'd0);
        @(posedge clk); #1;
`endif
        // Timeout: wait count runs 0..255 in BUSY, so 1 IDLE + 256 BUSY stall cycles
        drive(EXE_LW_OP, 32'h0000_0300, 32'h0, 5'd12, 1'b1, 32'h0);
        access("tmo", -1, 32'h5555_5555, 257, 4'b1111, 1'b0, 32'h0000_0300, 32'h0,
               5'd12, 1'b0, 32'h0, 1'b1);
        // Ack on the last BUSY cycle (count 255) wins over the timeout
        drive(EXE_LW_OP, 32'h0000_0400, 32'h0, 5'd13, 1'b1, 32'h0);
        access("ack255", 256, 32'h0BAD_F00D, 257, 4'b1111, 1'b0, 32'h0000_0400, 32'h0,
               5'd13, 1'b1, 32'h0BAD_F00D, 1'b0);

        // Reset in the middle of BUSY, then a stray ack afterwards
        drive(EXE_LW_OP, 32'h0000_0500, 32'h0, 5'd14, 1'b1, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rb_busy", 32'(fsm_state), 32'(BUSY));
        check("rb_req_before", 32'(dbus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rb_req_async", 32'(dbus_req), 32'd0);
        check("rb_stall_async", 32'(stallreq), 32'd0);
        check("rb_state_async", 32'(fsm_state), 32'(IDLE));
        drive_nop();
        @(posedge clk); #1;
        rst = 1'b1;
        dbus_ack = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rb_ack_req", 32'(dbus_req), 32'd0);
        check("rb_ack_wreg", 32'(mem_wreg), 32'd0);
        check("rb_ack_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rb_after_state", 32'(fsm_state), 32'(IDLE));
        check("rb_after_wdata", mem_wdata, 32'h0);
        check("rb_after_err", 32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
